// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control slice: controller states,
// pipeline-register indices and run-mode encodings.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP_WAIT,
    ST_STEP_EXEC,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  localparam int unsigned IDX_PC    = 0;
  localparam int unsigned IDX_IFID  = 1;
  localparam int unsigned IDX_IDEX  = 2;
  localparam int unsigned IDX_EXMEM = 3;
  localparam int unsigned IDX_MEMWB = 4;

  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction currently in ID. Register 0 never creates a dependency.
module hazard_detect #(
  parameter int unsigned NB = 5
) (
  input  logic          ex_mem_read,
  input  logic [NB-1:0] ex_rt,
  input  logic [NB-1:0] id_rs,
  input  logic [NB-1:0] id_rt,
  output logic          load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/pipeline_controller.sv
// Run/stall/flush controller for the N-stage MIPS pipeline: run modes, load-use
// stalls, branch flushes, HALT drain and a saturating advance counter.
module pipeline_controller
  import mips_pkg::*;
#(
  parameter int unsigned LEN      = 32,
  parameter int unsigned NB       = $clog2(LEN),
  parameter int unsigned N_STAGES = 5,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_mode,
  input  logic                in_start,
  input  logic                in_step,
  input  logic [NB-1:0]       in_id_rs,
  input  logic [NB-1:0]       in_id_rt,
  input  logic                in_ex_mem_read,
  input  logic [NB-1:0]       in_ex_rt,
  input  logic                in_pc_src_taken,
  input  logic                in_halt,
  output logic [N_STAGES-1:0] out_stage_en,
  output logic [N_STAGES-1:0] out_flush,
  output logic                out_running,
  output logic                out_done,
  output logic [CNT_W-1:0]    out_cycle_count
);

  localparam int unsigned DW = $clog2(N_STAGES);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(N_STAGES - 2);

  ctrl_state_e      state_q, state_d;
  logic             mode_q;
  logic [DW-1:0]    drain_cnt_q;
  logic             drain_go_q;
  logic [CNT_W-1:0] cycle_cnt_q;

  logic load_use;
  logic advance;
  logic halt_go;

  hazard_detect #(
    .NB (NB)
  ) u_hazard_detect (
    .ex_mem_read (in_ex_mem_read),
    .ex_rt       (in_ex_rt),
    .id_rs       (in_id_rs),
    .id_rt       (in_id_rt),
    .load_use    (load_use)
  );

  // A taken branch squashes both the stall and a HALT seen on the wrong path;
  // a stalled HALT is simply seen again on the following advance.
  always_comb begin
    halt_go = in_halt && !in_pc_src_taken && !load_use;
  end

  always_comb begin
    advance      = 1'b0;
    out_stage_en = '0;
    out_flush    = '0;
    state_d      = state_q;

    unique case (state_q)
      ST_RUN, ST_STEP_EXEC: advance = 1'b1;
      ST_DRAIN:             advance = (mode_q == MODE_CONT) || drain_go_q;
      default:              advance = 1'b0;
    endcase

    if (advance) begin
      out_stage_en = '1;
      if (state_q == ST_DRAIN) begin
        out_stage_en[IDX_PC]   = 1'b0;
        out_stage_en[IDX_IFID] = 1'b0;
        out_flush[IDX_IFID]    = 1'b1;
      end
      if (in_pc_src_taken) begin
        out_flush[IDX_IFID] = 1'b1;
        out_flush[IDX_IDEX] = 1'b1;
      end else if (load_use) begin
        out_stage_en[IDX_PC]   = 1'b0;
        out_stage_en[IDX_IFID] = 1'b0;
        out_flush[IDX_IDEX]    = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (in_start) state_d = (in_mode == MODE_STEP) ? ST_STEP_WAIT : ST_RUN;
      end
      ST_RUN: begin
        if (halt_go) state_d = ST_DRAIN;
      end
      ST_STEP_WAIT: begin
        if (in_step) state_d = ST_STEP_EXEC;
      end
      ST_STEP_EXEC: begin
        state_d = halt_go ? ST_DRAIN : ST_STEP_WAIT;
      end
      ST_DRAIN: begin
        if (advance && (drain_cnt_q == DW'(1))) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_running     = (state_q == ST_RUN) || (state_q == ST_STEP_EXEC) || (state_q == ST_DRAIN);
    out_done        = (state_q == ST_DONE);
    out_cycle_count = cycle_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_CONT;
      drain_cnt_q <= '0;
      drain_go_q  <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && in_start) mode_q <= in_mode;

      if ((state_q != ST_DRAIN) && (state_d == ST_DRAIN)) begin
        drain_cnt_q <= DRAIN_INIT;
      end else if ((state_q == ST_DRAIN) && advance) begin
        drain_cnt_q <= drain_cnt_q - DW'(1);
      end

      // Step-mode drain: a step pulse grants exactly one advance next clock,
      // and a pulse arriving during that advance is dropped.
      drain_go_q <= (state_q == ST_DRAIN) && (mode_q == MODE_STEP) && !drain_go_q && in_step;

      if (advance && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
    end
  end

endmodule
